mem_bus_master: RTL and testbench

Single-outstanding initiator for the team's 4-entry x 8-bit memory bus. It accepts read/write commands on a valid/ready port, drives one-cycle `wen`/`ren` strobes with `addr`/`wdata` onto the memory bus, and captures the registered `rdata` returned one cycle after `ren`. It returns each result on a valid/ready response port. It sits between test/control logic and the memory and owns all bus timing.

---
 rtl/mem_bus_master_if.sv | 34 +++
 rtl/mem_bus_master.sv | 186 ++++++++++++++++++
 tb/tb_mem_bus_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_if.sv
// Command/response handshake and memory-bus signals of mem_bus_master.
// The master modport is the initiator's view; slave is the control/memory side.
interface mem_bus_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;
    logic              m_wen;
    logic              m_ren;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, m_rdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, init_done,
               m_wen, m_ren, m_addr, m_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, m_rdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, init_done,
               m_wen, m_ren, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_bus_master.sv
// Single-outstanding read/write initiator for the 4 x 8 memory bus, registered outputs.
// Optional MEM_INIT_EN: after reset, fill every memory entry with INIT_VAL before accepting commands.
module mem_bus_master #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
`ifdef MEM_INIT_EN
    , parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
`endif
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3
`ifdef MEM_INIT_EN
        , ST_INIT = 3'd4
`endif
    } state_t;

`ifdef MEM_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              m_wen_q, m_wen_d;
    logic              m_ren_q, m_ren_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              accept_s;
`ifdef MEM_INIT_EN
    // Extra MSB flags sweep completion once every address has been written.
    logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
`endif

    assign accept_s = bus.cmd_valid && cmd_ready_q;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cmd_ready_q <= RST_READY;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            m_wen_q     <= 1'b0;
            m_ren_q     <= 1'b0;
            m_addr_q    <= {ADDR_W{1'b0}};
            m_wdata_q   <= {DATA_W{1'b0}};
`ifdef MEM_INIT_EN
            init_cnt_q  <= {(ADDR_W+1){1'b0}};
            init_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            m_wen_q     <= m_wen_d;
            m_ren_q     <= m_ren_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
`ifdef MEM_INIT_EN
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_ISSUE;
                else          state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (rsp_write_q) state_d = ST_RESP;
                else             state_d = ST_WAIT;
            end
            ST_WAIT: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
                else               state_d = ST_RESP;
            end
`ifdef MEM_INIT_EN
            ST_INIT: begin
                if (init_cnt_q[ADDR_W]) state_d = ST_IDLE;
                else                    state_d = ST_INIT;
            end
`endif
            default: state_d = RST_STATE;
        endcase
    end

    // Next values of the registered outputs; strobes default low so each lasts one cycle.
    always_comb begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        m_wen_d     = 1'b0;
        m_ren_d     = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
`ifdef MEM_INIT_EN
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    m_wen_d     = bus.cmd_write;
                    m_ren_d     = !bus.cmd_write;
                    m_addr_d    = bus.cmd_addr;
                    m_wdata_d   = bus.cmd_wdata;
                    rsp_write_d = bus.cmd_write;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (rsp_write_q) begin
                    rsp_rdata_d = m_wdata_q;
                    rsp_valid_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                rsp_rdata_d = bus.m_rdata;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (bus.rsp_ready) cmd_ready_d = 1'b1;
                else               rsp_valid_d = 1'b1;
            end
`ifdef MEM_INIT_EN
            ST_INIT: begin
                if (!init_cnt_q[ADDR_W]) begin
                    m_wen_d    = 1'b1;
                    m_addr_d   = init_cnt_q[ADDR_W-1:0];
                    m_wdata_d  = INIT_VAL;
                    init_cnt_d = init_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    init_done_d = 1'b1;
                    cmd_ready_d = 1'b1;
                end
            end
`endif
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.m_wen     = m_wen_q;
    assign bus.m_ren     = m_ren_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
`ifdef MEM_INIT_EN
    assign bus.init_done = init_done_q;
`else
    assign bus.init_done = 1'b1;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural 4 x 8 registered-read memory.
module tb_mem_bus_master;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
`ifdef MEM_INIT_EN
    localparam logic [7:0] FILL    = 8'h3C;
    localparam logic       RST_RDY = 1'b0;
`else
    localparam logic [7:0] FILL    = 8'hFF;
    localparam logic       RST_RDY = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wen_cnt = 0;
    int   ren_cnt = 0;
    int   overlap = 0;
    logic [7:0] mem [4];

    mem_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
`ifdef MEM_INIT_EN
        , .INIT_VAL(8'h3C)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Memory model: resets to FF, rdata registered on the edge that samples ren; strobe monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'hFF;
            bus.m_rdata <= 8'h00;
        end else begin
            if (bus.m_wen) mem[bus.m_addr] <= bus.m_wdata;
            if (bus.m_ren) bus.m_rdata <= mem[bus.m_addr];
        end
        if (bus.m_wen) wen_cnt <= wen_cnt + 1;
        if (bus.m_ren) ren_cnt <= ren_cnt + 1;
        if (bus.m_wen && bus.m_ren) overlap <= overlap + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transaction with rsp_ready already high; lat counts cycles from accept edge to rsp_valid.
    task automatic xact(input logic wr, input logic [1:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic rw);
        int g;
        g = 0;
        while (!bus.cmd_ready && g < 20) begin step(); g++; end
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
        bus.rsp_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin step(); lat++; end
        rd = bus.rsp_rdata;
        rw = bus.rsp_write;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, g, base;
        int acc [4];
        logic [7:0] rd;
        logic rw;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 2'd0;
        bus.cmd_wdata = 8'h00; bus.rsp_ready = 1'b0;
        repeat (3) step();

        chk("rst_cmd_ready", bus.cmd_ready, RST_RDY);
        chk("rst_init_done", bus.init_done, RST_RDY);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_strobes", {bus.m_wen, bus.m_ren}, 2'b00);
        chk("rst_m_addr", bus.m_addr, 2'd0);
        chk("rst_m_wdata", bus.m_wdata, 8'h00);
        chk("rst_rsp", {bus.rsp_write, bus.rsp_rdata}, 9'h000);
        rst = 1'b0;
        mem_rst = 1'b0;

`ifdef MEM_INIT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            chk("init_wen", {bus.m_wen, bus.m_ren}, 2'b10);
            chk("init_addr", bus.m_addr, i);
            chk("init_wdata", bus.m_wdata, 8'h3C);
            chk("init_done_low", {bus.init_done, bus.cmd_ready}, 2'b00);
        end
        step();
        chk("init_done_rise", {bus.init_done, bus.cmd_ready}, 2'b11);
        chk("init_wen_end", bus.m_wen, 1'b0);
`endif

        // Read addr 2 of untouched memory, hand-checked cycle by cycle.
        base = ren_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 2'd2; bus.cmd_wdata = 8'h5A;
        step();
        bus.cmd_valid = 1'b0;
        chk("rd1_k1_strobes", {bus.m_wen, bus.m_ren}, 2'b01);
        chk("rd1_k1_addr", bus.m_addr, 2'd2);
        chk("rd1_k1_ready_valid", {bus.cmd_ready, bus.rsp_valid}, 2'b00);
        step();
        chk("rd1_k2_quiet", {bus.m_ren, bus.rsp_valid}, 2'b00);
        step();
        chk("rd1_k3_valid", bus.rsp_valid, 1'b1);
        chk("rd1_k3_data", bus.rsp_rdata, FILL);
        chk("rd1_k3_write", bus.rsp_write, 1'b0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("rd1_done", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        chk("rd1_ren_cycles", ren_cnt - base, 1);

        // Write A5 to addr 1, then read it back.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 2'd1; bus.cmd_wdata = 8'hA5;
        step();
        bus.cmd_valid = 1'b0;
        chk("wr1_k1_strobes", {bus.m_wen, bus.m_ren}, 2'b10);
        chk("wr1_k1_bus", {bus.m_addr, bus.m_wdata}, {2'd1, 8'hA5});
        step();
        chk("wr1_k2_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_rdata}, {2'b11, 8'hA5});
        chk("wr1_k2_wen_off", bus.m_wen, 1'b0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("wr1_ready_next", bus.cmd_ready, 1'b1);
        xact(1'b0, 2'd1, 8'h00, lat, rd, rw);
        chk("rd_a5_lat", lat, 3);
        chk("rd_a5_data", {rw, rd}, {1'b0, 8'hA5});
        chk("rd_a5_ready_next", bus.cmd_ready, 1'b1);

        // Backpressure on a read of addr 0.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 2'd0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        base = wen_cnt + ren_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {bus.rsp_valid, bus.cmd_ready, bus.m_wen, bus.m_ren}, 4'b1000);
            chk("bp_data", {bus.rsp_write, bus.rsp_rdata}, {1'b0, FILL});
            step();
        end
        chk("bp_no_strobes", wen_cnt + ren_cnt - base, 0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("bp_release", {bus.rsp_valid, bus.cmd_ready}, 2'b01);

        // Back-to-back writes with cmd_valid held high; accept spacing must be 3.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = 0;
            while (!bus.cmd_ready && g < 10) begin step(); g++; end
            bus.cmd_addr = i[1:0];
            bus.cmd_wdata = 8'(8'h11 * (i + 1));
            step();
            acc[i] = cyc;
        end
        bus.cmd_valid = 1'b0;
        repeat (3) step();
        bus.rsp_ready = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, i[1:0], 8'h00, lat, rd, rw);
            chk("b2b_read_data", rd, 8'(8'h11 * (i + 1)));
        end
        chk("no_overlap", overlap, 0);

        // Reset while a read of addr 3 sits in WAIT.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 2'd3; bus.cmd_wdata = 8'h77;
        step();
        bus.cmd_valid = 1'b0;
        chk("rst_rd_issue", {bus.m_ren, bus.m_addr, bus.m_wdata}, {1'b1, 2'd3, 8'h77});
        step();
        chk("rst_rd_wait", {bus.m_ren, bus.rsp_valid}, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ctrl", {bus.cmd_ready, bus.rsp_valid, bus.m_wen, bus.m_ren}, {RST_RDY, 3'b000});
        chk("mid_rst_bus", {bus.m_addr, bus.m_wdata}, 10'h000);
        chk("mid_rst_rsp", {bus.rsp_write, bus.rsp_rdata}, 9'h000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_no_rsp", bus.rsp_valid, 1'b0);
        end
        g = 0;
        while (!bus.init_done && g < 20) begin step(); g++; end
        chk("mid_rst_init_done", bus.init_done, 1'b1);
`ifdef MEM_INIT_EN
        xact(1'b0, 2'd3, 8'h00, lat, rd, rw);
        chk("post_rst_read", {lat[3:0], rd}, {4'd3, 8'h3C});
`else
        xact(1'b0, 2'd3, 8'h00, lat, rd, rw);
        chk("post_rst_read", {lat[3:0], rd}, {4'd3, 8'h44});
`endif
        xact(1'b1, 2'd2, 8'hC3, lat, rd, rw);
        chk("post_rst_write", {lat[3:0], rw, rd}, {4'd2, 1'b1, 8'hC3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
